// File: rtl/tim_ctrl.sv
// Register-mapped sequencer for one 16-bit timer: shadow PSC/ARR, restart FSM, UIF/OVR status, level irq.
// Optional event counter register at 0x18 is built when TIM_CTRL_EVT_CNT_EN is defined.
module tim_ctrl #(
    parameter int          ADDR_W  = 5,
    parameter logic [15:0] RST_PSC = 16'h0000,
    parameter logic [15:0] RST_ARR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ready,
    output logic              tim_en,
    output logic              tim_countdown,
    output logic [15:0]       tim_psc,
    output logic [15:0]       tim_arr,
    input  logic [15:0]       tim_cnt,
    input  logic              tim_evt,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        STOP
    } state_t;

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_PSC  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_ARR  = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_EGR  = ADDR_W'(8'h14);
`ifdef TIM_CTRL_EVT_CNT_EN
    localparam logic [ADDR_W-1:0] A_EVT  = ADDR_W'(8'h18);
`endif

    state_t      state;
    logic        ctrl_en;
    logic        ctrl_dir;
    logic        ctrl_opm;
    logic        ctrl_ie;
    logic [15:0] psc_sh;
    logic [15:0] arr_sh;
    logic        uif;
    logic        ovr;
    logic [31:0] rd_val;

    logic [ADDR_W-1:0] addr_w;
    logic acc;
    logic wr;
    logic wr_ctrl;
    logic wr_psc;
    logic wr_arr;
    logic wr_stat;
    logic wr_egr;
    logic en_clr;
    logic ug;
    logic run_stop;
    logic evt_run;
    logic uif_clr;
    logic ovr_clr;
    logic unused_ok;

    assign addr_w   = {bus_addr[ADDR_W-1:2], 2'b00};
    assign acc      = bus_sel & ~bus_ready;
    assign wr       = acc & bus_we;
    assign wr_ctrl  = wr && (addr_w == A_CTRL);
    assign wr_psc   = wr && (addr_w == A_PSC);
    assign wr_arr   = wr && (addr_w == A_ARR);
    assign wr_stat  = wr && (addr_w == A_STAT);
    assign wr_egr   = wr && (addr_w == A_EGR);
    assign en_clr   = wr_ctrl & ~bus_wdata[0];
    assign ug       = wr_egr & bus_wdata[0];
    assign run_stop = en_clr | ~ctrl_en;
    assign evt_run  = tim_evt & (state == RUN);
    assign uif_clr  = wr_stat & bus_wdata[0];
    assign ovr_clr  = wr_stat & bus_wdata[2];
    assign unused_ok = &{1'b0, bus_wdata[31:16], bus_addr[1:0]};

    assign tim_countdown = ctrl_dir;

`ifdef TIM_CTRL_EVT_CNT_EN
    logic [7:0] evt_cnt;
    logic       rd_evt;

    assign rd_evt = acc && !bus_we && (addr_w == A_EVT);

    // Saturating event count; a read clears it, an event in that cycle counts as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= 8'd0;
        end else if (rd_evt) begin
            evt_cnt <= evt_run ? 8'd1 : 8'd0;
        end else if (evt_run && evt_cnt != 8'hFF) begin
            evt_cnt <= evt_cnt + 8'd1;
        end
    end
`endif

    // Read mux; unmapped and write-only locations return 0.
    always_comb begin
        rd_val = 32'h0;
        case (addr_w)
            A_CTRL: rd_val = {28'h0, ctrl_ie, ctrl_opm, ctrl_dir, ctrl_en};
            A_PSC:  rd_val = {16'h0, psc_sh};
            A_ARR:  rd_val = {16'h0, arr_sh};
            A_STAT: rd_val = {29'h0, ovr, tim_en, uif};
            A_CNT:  rd_val = {16'h0, tim_cnt};
`ifdef TIM_CTRL_EVT_CNT_EN
            A_EVT:  rd_val = {24'h0, evt_cnt};
`endif
            default: rd_val = 32'h0;
        endcase
    end

    // Bus handshake: accept when idle, answer one cycle later with a ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ready <= 1'b0;
            bus_rdata <= 32'h0;
        end else if (acc) begin
            bus_ready <= 1'b1;
            bus_rdata <= bus_we ? 32'h0 : rd_val;
        end else begin
            bus_ready <= 1'b0;
        end
    end

    // Control and shadow registers; STOP retires EN after a one-shot run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en  <= 1'b0;
            ctrl_dir <= 1'b0;
            ctrl_opm <= 1'b0;
            ctrl_ie  <= 1'b0;
            psc_sh   <= RST_PSC;
            arr_sh   <= RST_ARR;
        end else begin
            if (wr_ctrl) begin
                ctrl_en  <= bus_wdata[0];
                ctrl_dir <= bus_wdata[1];
                ctrl_opm <= bus_wdata[2];
                ctrl_ie  <= bus_wdata[3];
            end
            if (state == STOP) begin
                ctrl_en <= 1'b0;
            end
            if (wr_psc) begin
                psc_sh <= bus_wdata[15:0];
            end
            if (wr_arr) begin
                arr_sh <= bus_wdata[15:0];
            end
        end
    end

    // Sticky status flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uif <= 1'b0;
            ovr <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (evt_run) begin
                uif <= 1'b1;
            end else if (uif_clr) begin
                uif <= 1'b0;
            end
            if (evt_run && uif && !uif_clr) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
            irq <= uif & ctrl_ie;
        end
    end

    // Sequencer: owns the enable and the active PSC/ARR copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tim_en  <= 1'b0;
            tim_psc <= RST_PSC;
            tim_arr <= RST_ARR;
        end else begin
            case (state)
                IDLE: begin
                    tim_en <= 1'b0;
                    if (ug) begin
                        tim_psc <= psc_sh;
                        tim_arr <= arr_sh;
                    end
                    if (ctrl_en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tim_psc <= psc_sh;
                    tim_arr <= arr_sh;
                    tim_en  <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (run_stop) begin
                        tim_en <= 1'b0;
                        state  <= IDLE;
                    end else if (ug) begin
                        tim_en <= 1'b0;
                        state  <= LOAD;
                    end else if (tim_evt) begin
                        if (ctrl_opm) begin
                            tim_en <= 1'b0;
                            state  <= STOP;
                        end else begin
                            tim_psc <= psc_sh;
                            tim_arr <= arr_sh;
                        end
                    end
                end
                STOP: begin
                    tim_en <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    tim_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tim_ctrl.sv
// Bench for tim_ctrl: directed bus/event vectors, read data checked by a queue-driven monitor.
// Event-counter expectations follow TIM_CTRL_EVT_CNT_EN.
module tb_tim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_sel;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        tim_en;
    logic        tim_countdown;
    logic [15:0] tim_psc;
    logic [15:0] tim_arr;
    logic [15:0] tim_cnt;
    logic        tim_evt;
    logic        irq;

`ifdef TIM_CTRL_EVT_CNT_EN
    localparam bit HAS_EVT = 1'b1;
`else
    localparam bit HAS_EVT = 1'b0;
`endif

    localparam logic [4:0] A_CTRL = 5'h00;
    localparam logic [4:0] A_PSC  = 5'h04;
    localparam logic [4:0] A_ARR  = 5'h08;
    localparam logic [4:0] A_STAT = 5'h0C;
    localparam logic [4:0] A_CNT  = 5'h10;
    localparam logic [4:0] A_EGR  = 5'h14;
    localparam logic [4:0] A_EVT  = 5'h18;
    localparam logic [4:0] A_UNM  = 5'h1C;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    tim_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_sel(bus_sel),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .tim_en(tim_en),
        .tim_countdown(tim_countdown),
        .tim_psc(tim_psc),
        .tim_arr(tim_arr),
        .tim_cnt(tim_cnt),
        .tim_evt(tim_evt),
        .irq(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: each ready pulse retires the oldest issued access.
    always @(negedge clk) begin
        if (rst_n && bus_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_ready: got ready with no access pending, expected none");
            end else begin
                logic [31:0] e;
                bit          c;
                string       n;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                n = name_q.pop_front();
                if (c) chk(n, bus_rdata, e);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit we, input logic [4:0] a, input logic [31:0] wd,
                       input bit evt, input logic [31:0] exp, input string nm);
        @(negedge clk);
        if (bus_ready) @(negedge clk);
        exp_q.push_back(exp);
        chk_q.push_back(!we);
        name_q.push_back(nm);
        bus_sel   = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = wd;
        tim_evt   = evt;
        @(posedge clk);
        #1;
        bus_sel = 1'b0;
        bus_we  = 1'b0;
        tim_evt = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, a, 32'h0, 1'b0, exp, nm);
    endtask

    task automatic pulse();
        @(negedge clk);
        tim_evt = 1'b1;
        @(posedge clk);
        #1;
        tim_evt = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 5'h0;
        bus_wdata = 32'h0;
        tim_cnt   = 16'h1234;
        tim_evt   = 1'b0;
        cyc(2);
        chk("rst_en", tim_en, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ready", bus_ready, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_psc", tim_psc, 0);
        chk("rst_arr", tim_arr, 32'hFFFF);
        chk("rst_dir", tim_countdown, 0);
        @(negedge clk);
        rst_n = 1'b1;

        rd(A_CTRL, 32'h0, "rd_ctrl_rst");
        rd(A_STAT, 32'h0, "rd_stat_rst");
        rd(A_PSC, 32'h0, "rd_psc_rst");
        rd(A_ARR, 32'hFFFF, "rd_arr_rst");

        wr(A_PSC, 5);
        wr(A_ARR, 10);
        chk("shadow_only_arr", tim_arr, 32'hFFFF);
        chk("shadow_only_psc", tim_psc, 0);
        wr(A_CTRL, 32'h9);
        chk("en_idle", tim_en, 0);
        @(negedge clk);
        @(negedge clk);
        chk("en_load", tim_en, 0);
        chk("arr_load", tim_arr, 32'hFFFF);
        @(negedge clk);
        chk("en_run", tim_en, 1);
        chk("psc_run", tim_psc, 5);
        chk("arr_run", tim_arr, 10);
        rd(A_STAT, 32'h2, "rd_stat_run");
        rd(A_CNT, 32'h1234, "rd_cnt");
        rd(A_EGR, 32'h0, "rd_egr");
        rd(A_UNM, 32'h0, "rd_unmapped");
        rd(A_CTRL, 32'h9, "rd_ctrl_9");

        wr(A_ARR, 20);
        chk("arr_hold", tim_arr, 10);
        cyc(2);
        chk("arr_hold2", tim_arr, 10);
        pulse();
        chk("arr_preload", tim_arr, 20);
        chk("irq_lag", irq, 0);
        cyc(1);
        chk("irq_set", irq, 1);
        rd(A_STAT, 32'h3, "rd_stat_uif");

        pulse();
        rd(A_STAT, 32'h7, "rd_stat_ovr");
        bus(1'b1, A_STAT, 32'h5, 1'b1, 32'h0, "wr");
        rd(A_STAT, 32'h3, "rd_stat_setwins");
        chk("irq_hold", irq, 1);
        wr(A_STAT, 32'h1);
        rd(A_STAT, 32'h2, "rd_stat_clr");
        chk("irq_clr", irq, 0);

        wr(A_PSC, 7);
        wr(A_EGR, 32'h1);
        chk("ug_en_low", tim_en, 0);
        chk("ug_psc_old", tim_psc, 5);
        @(negedge clk);
        chk("ug_en_low2", tim_en, 0);
        @(negedge clk);
        chk("ug_en_high", tim_en, 1);
        chk("ug_psc_new", tim_psc, 7);
        chk("ug_arr", tim_arr, 20);

        wr(A_CTRL, 32'hD);
        pulse();
        chk("opm_en", tim_en, 0);
        cyc(1);
        rd(A_CTRL, 32'hC, "rd_ctrl_opm");
        rd(A_STAT, 32'h1, "rd_stat_opm");
        cyc(3);
        chk("opm_idle", tim_en, 0);

        wr(A_STAT, 32'h1);
        pulse();
        rd(A_STAT, 32'h0, "rd_stat_idle_evt");

        wr(A_ARR, 32'h30);
        chk("idle_arr_hold", tim_arr, 20);
        wr(A_EGR, 32'h1);
        chk("idle_ug_arr", tim_arr, 32'h30);
        chk("idle_ug_en", tim_en, 0);
        cyc(3);
        chk("idle_ug_stay", tim_en, 0);

        wr(A_CTRL, 32'h2);
        chk("dir_down", tim_countdown, 1);
        wr(A_CTRL, 32'h0);
        chk("dir_up", tim_countdown, 0);

        wr(A_CTRL, 32'h9);
        cyc(3);
        chk("re_run", tim_en, 1);
        bus(1'b1, A_CTRL, 32'h8, 1'b1, 32'h0, "wr");
        chk("clr_evt_en", tim_en, 0);
        cyc(1);
        chk("clr_evt_irq", irq, 1);
        rd(A_STAT, 32'h1, "rd_stat_clr_evt");
        cyc(3);
        chk("clr_evt_idle", tim_en, 0);
        wr(A_STAT, 32'h1);

        wr(A_CTRL, 32'h1);
        cyc(3);
        chk("cnt_run", tim_en, 1);
        repeat (300) pulse();
        rd(A_EVT, HAS_EVT ? 32'd255 : 32'd0, "rd_evt_sat");
        rd(A_EVT, 32'd0, "rd_evt_cleared");
        repeat (3) pulse();
        bus(1'b0, A_EVT, 32'h0, 1'b1, HAS_EVT ? 32'd3 : 32'd0, "rd_evt_3");
        rd(A_EVT, HAS_EVT ? 32'd1 : 32'd0, "rd_evt_one");

        wr(A_CTRL, 32'h9);
        pulse();
        cyc(1);
        chk("pre_rst_irq", irq, 1);
        chk("pre_rst_en", tim_en, 1);
        chk("pre_rst_arr", tim_arr, 32'h30);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", tim_en, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_arr", tim_arr, 32'hFFFF);
        chk("mid_rst_psc", tim_psc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_STAT, 32'h0, "rd_stat_post_rst");
        rd(A_CTRL, 32'h0, "rd_ctrl_post_rst");
        rd(A_ARR, 32'hFFFF, "rd_arr_post_rst");

        cyc(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
